// File: rtl/control_pila.sv
// rtl/control_pila.sv - call/return sequencer driving the program stack
//
// Turns single-cycle call/ret requests from the decoder into push/pop
// operations on the stack, returns the popped address to the PC mux with a
// one-cycle valid strobe, and tracks the stack depth.
//
// Optional protection: define CONTROL_PILA_PROTECCION_EN to enable the
// full/empty checks and the sticky desbordamiento/subdesbordamiento flags.
// Without it every request is issued, the depth wraps and both flags read 0.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   call, ret           push / pop requests, sampled only in REPOSO
//   dir_retorno         address to push, sampled together with call
//   pila_salida         stack top-of-stack word (registered by the stack)
//   pila_activa         stack enable
//   pila_push           1 = push, 0 = pop (when pila_activa = 1)
//   pila_datos          data to push
//   pc_retorno          captured return address
//   retorno_valido      one-cycle strobe for a newly captured pc_retorno
//   ocupado             high whenever the sequencer is not in REPOSO
//   profundidad         number of entries on the stack
//   desbordamiento      sticky overflow flag
//   subdesbordamiento   sticky underflow flag
module control_pila #(
  parameter int DATA  = 10,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     call,
  input  logic                     ret,
  input  logic [DATA-1:0]          dir_retorno,
  input  logic [DATA-1:0]          pila_salida,
  output logic                     pila_activa,
  output logic                     pila_push,
  output logic [DATA-1:0]          pila_datos,
  output logic [DATA-1:0]          pc_retorno,
  output logic                     retorno_valido,
  output logic                     ocupado,
  output logic [$clog2(DEPTH)-1:0] profundidad,
  output logic                     desbordamiento,
  output logic                     subdesbordamiento
);

  localparam int PW = $clog2(DEPTH);
  // Word 0 of the stack is never written, so usable capacity is DEPTH-1.
  localparam logic [PW-1:0] LLENO = PW'(DEPTH - 1);

  typedef enum logic [1:0] {REPOSO, EMPUJA, SACA, ESPERA} estado_t;

  estado_t estado;
  logic    lleno;
  logic    vacio;

`ifdef CONTROL_PILA_PROTECCION_EN
  assign lleno = (profundidad == LLENO);
  assign vacio = (profundidad == '0);
`else
  assign lleno             = 1'b0;
  assign vacio             = 1'b0;
  assign desbordamiento    = 1'b0;
  assign subdesbordamiento = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado            <= REPOSO;
      pila_activa       <= 1'b0;
      pila_push         <= 1'b0;
      pila_datos        <= '0;
      pc_retorno        <= '0;
      retorno_valido    <= 1'b0;
      ocupado           <= 1'b0;
      profundidad       <= '0;
`ifdef CONTROL_PILA_PROTECCION_EN
      desbordamiento    <= 1'b0;
      subdesbordamiento <= 1'b0;
`endif
    end else begin
      case (estado)
        REPOSO: begin
          // call has priority; a simultaneous ret is dropped.
          if (call) begin
            if (lleno) begin
`ifdef CONTROL_PILA_PROTECCION_EN
              desbordamiento <= 1'b1;
`endif
            end else begin
              pila_datos  <= dir_retorno;
              pila_activa <= 1'b1;
              pila_push   <= 1'b1;
              ocupado     <= 1'b1;
              estado      <= EMPUJA;
            end
          end else if (ret) begin
            if (vacio) begin
`ifdef CONTROL_PILA_PROTECCION_EN
              subdesbordamiento <= 1'b1;
`endif
            end else begin
              // Top of stack is already stable thanks to the ESPERA settle
              // cycle, so the return address is captured before the pop.
              pc_retorno     <= pila_salida;
              retorno_valido <= 1'b1;
              pila_activa    <= 1'b1;
              pila_push      <= 1'b0;
              ocupado        <= 1'b1;
              estado         <= SACA;
            end
          end
        end
        EMPUJA: begin
          // Depth tracks the stack pointer: it moves at the push edge.
          profundidad <= profundidad + 1'b1;
          pila_activa <= 1'b0;
          pila_push   <= 1'b0;
          estado      <= ESPERA;
        end
        SACA: begin
          profundidad    <= profundidad - 1'b1;
          pila_activa    <= 1'b0;
          retorno_valido <= 1'b0;
          estado         <= ESPERA;
        end
        ESPERA: begin
          ocupado <= 1'b0;
          estado  <= REPOSO;
        end
        default: begin
          pila_activa    <= 1'b0;
          pila_push      <= 1'b0;
          retorno_valido <= 1'b0;
          ocupado        <= 1'b0;
          estado         <= REPOSO;
        end
      endcase
    end
  end

endmodule
